pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/riscv_defines.sv | 15 +
 rtl/ras_stack.sv | 59 +++++
 rtl/pc_fetch_ctrl.sv | 81 ++++++++
 tb/tb_pc_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared constants and the next-PC source enum for the fetch front end.
package riscv_defines;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          RAS_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    TRAP,
    MISPRED,
    RAS,
    PRED,
    SEQ
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; the oldest entry is overwritten when full.
module ras_stack
  import riscv_defines::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] push_data,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic [PTR_W-1:0] wr_idx;

  assign do_pop = pop && (count != '0);
  // A simultaneous pop+push overwrites the current top in place.
  assign wr_idx = do_pop ? ptr : ptr + 1'b1;
  assign top    = mem[ptr];
  assign empty  = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (clear) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      ptr   <= ptr;
      count <= count;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CNT_W'(DEPTH)) begin
        count <= count + 1'b1;
      end
    end else if (do_pop) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register with prioritised next-PC selection and a return-address stack.
module pc_fetch_ctrl
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter int          RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        trap_redir,
  input  logic [31:0] trap_addr,
  input  logic        mispredict,
  input  logic        cflow_taken,
  input  logic [31:0] pc_jump,
  input  logic [31:0] pc_return,
  input  logic        pred_taken,
  input  logic [31:0] pc_pred,
  input  logic        pred_call,
  input  logic        pred_ret,
  output logic [31:0] pc_f,
  output logic [31:0] pcplus4_f,
  output logic [31:0] pc_next,
  output logic        ras_empty
);

  pc_sel_e     pc_sel;
  logic [31:0] ras_top;
  logic        accept;
  logic        ras_push;
  logic        ras_pop;
  logic        load_pc;

  assign pcplus4_f = pc_f + 32'd4;
  assign load_pc   = !stall_f || trap_redir || mispredict;
  // Speculative RAS updates only happen when fetch actually advances without redirect.
  assign accept    = !stall_f && !trap_redir && !mispredict;
  assign ras_push  = accept && pred_call;
  assign ras_pop   = accept && pred_ret && !ras_empty;

  always_comb begin
    pc_sel = SEQ;
    if (trap_redir)                   pc_sel = TRAP;
    else if (mispredict)              pc_sel = MISPRED;
    else if (pred_ret && !ras_empty)  pc_sel = RAS;
    else if (pred_taken)              pc_sel = PRED;
  end

  always_comb begin
    pc_next = pcplus4_f;
    case (pc_sel)
      TRAP:    pc_next = trap_addr;
      MISPRED: pc_next = cflow_taken ? pc_jump : pc_return;
      RAS:     pc_next = ras_top;
      PRED:    pc_next = pc_pred;
      default: pc_next = pcplus4_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f <= RESET_VEC;
    end else if (load_pc) begin
      pc_f <= pc_next;
    end
  end

  ras_stack #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .clear    (trap_redir),
    .push_data(pcplus4_f),
    .top      (ras_top),
    .empty    (ras_empty)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks of pc_fetch_ctrl against a queue-based fetch model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV    = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f, trap_redir, mispredict, cflow_taken;
  logic        pred_taken, pred_call, pred_ret;
  logic [31:0] trap_addr, pc_jump, pc_return, pc_pred;
  logic [31:0] pc_f, pcplus4_f, pc_next;
  logic        ras_empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras [$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_VEC(RV),
    .RAS_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_f    (stall_f),
    .trap_redir (trap_redir),
    .trap_addr  (trap_addr),
    .mispredict (mispredict),
    .cflow_taken(cflow_taken),
    .pc_jump    (pc_jump),
    .pc_return  (pc_return),
    .pred_taken (pred_taken),
    .pc_pred    (pc_pred),
    .pred_call  (pred_call),
    .pred_ret   (pred_ret),
    .pc_f       (pc_f),
    .pcplus4_f  (pcplus4_f),
    .pc_next    (pc_next),
    .ras_empty  (ras_empty)
  );

  function automatic logic [31:0] model_next();
    if (trap_redir)                        return trap_addr;
    if (mispredict)                        return cflow_taken ? pc_jump : pc_return;
    if (pred_ret && m_ras.size() > 0)      return m_ras[$];
    if (pred_taken)                        return pc_pred;
    return m_pc + 32'd4;
  endfunction

  task automatic set_idle();
    stall_f = 0; trap_redir = 0; mispredict = 0; cflow_taken = 0;
    pred_taken = 0; pred_call = 0; pred_ret = 0;
    trap_addr = 0; pc_jump = 0; pc_return = 0; pc_pred = 0;
  endtask

  // Advance one clock and apply the architectural effect of the current inputs to the model.
  task automatic tick();
    logic [31:0] nxt, pc4;
    nxt = model_next();
    pc4 = m_pc + 32'd4;
    @(posedge clk);
    if (!stall_f || trap_redir || mispredict) m_pc = nxt;
    if (trap_redir) m_ras.delete();
    else if (!stall_f && !mispredict) begin
      if (pred_ret && m_ras.size() > 0) void'(m_ras.pop_back());
      if (pred_call) begin
        m_ras.push_back(pc4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    set_idle(); trap_redir = 1; trap_addr = a;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    #2 rst_n = 0;
    m_pc = RV; m_ras.delete();
    #2;
    n_checks++; if (pc_f !== RV) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_f, RV); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", ras_empty); end
    @(posedge clk); #1;
    n_checks++; if (pc_f !== RV) begin n_fail++; $display("FAIL reset_hold got=%h exp=%h", pc_f, RV); end
    @(negedge clk) rst_n = 1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'h8000_0000; exp_seq[1] = 32'h8000_0004; exp_seq[2] = 32'h8000_0008;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (pc_f !== exp_seq[i]) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc_f, exp_seq[i]); end
      tick();
    end
  endtask

  task automatic test_pcplus4_wrap();
    redirect_to(32'hFFFF_FFFC);
    n_checks++; if (pcplus4_f !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4 got=%h exp=00000000", pcplus4_f); end
    tick();
    n_checks++; if (pc_f !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=00000000", pc_f); end
  endtask

  task automatic test_trap_priority();
    redirect_to(32'h0000_0400);
    pred_call = 1; tick(); set_idle();
    trap_redir = 1; trap_addr = 32'h0000_7000; mispredict = 1; cflow_taken = 1;
    pc_jump = 32'h0000_1234; pred_taken = 1; pc_pred = 32'h0000_5678; stall_f = 1; pred_call = 1;
    #1;
    n_checks++; if (pc_next !== 32'h0000_7000) begin n_fail++; $display("FAIL trap_next got=%h exp=00007000", pc_next); end
    tick(); set_idle();
    n_checks++; if (pc_f !== 32'h0000_7000) begin n_fail++; $display("FAIL trap_pc got=%h exp=00007000", pc_f); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL trap_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_call_return();
    redirect_to(32'h0000_0100);
    pred_call = 1; tick(); set_idle();
    tick();
    pred_ret = 1; #1;
    n_checks++; if (pc_next !== 32'h0000_0104) begin n_fail++; $display("FAIL ret_next got=%h exp=00000104", pc_next); end
    tick(); set_idle();
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_overflow();
    logic [31:0] a [9];
    redirect_to(32'h0000_1000);
    for (int i = 0; i < 9; i++) begin
      a[i] = 32'h0000_1000 + 32'(i) * 32'h100 + 32'd4;
      pred_call = 1; pred_taken = 1; pc_pred = 32'h0000_1000 + 32'(i + 1) * 32'h100;
      tick();
    end
    set_idle();
    for (int k = 0; k < 8; k++) begin
      pred_ret = 1; #1;
      n_checks++; if (pc_next !== a[8-k]) begin n_fail++; $display("FAIL ovf_pop%0d got=%h exp=%h", k, pc_next, a[8-k]); end
      tick();
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got=%b exp=1", ras_empty); end
    pred_ret = 1; pred_taken = 1; pc_pred = 32'hDEAD_0000; #1;
    n_checks++; if (pc_next !== 32'hDEAD_0000) begin n_fail++; $display("FAIL ovf_fallback got=%h exp=dead0000", pc_next); end
    tick(); set_idle();
    pred_ret = 1; #1;
    n_checks++; if (pc_next !== 32'hDEAD_0004) begin n_fail++; $display("FAIL ovf_seq got=%h exp=dead0004", pc_next); end
    tick(); set_idle();
  endtask

  task automatic test_call_ret_same();
    redirect_to(32'h0000_004C);
    pred_call = 1; pred_taken = 1; pc_pred = 32'h0000_0200; tick(); set_idle();
    pred_call = 1; pred_ret = 1; #1;
    n_checks++; if (pc_next !== 32'h0000_0050) begin n_fail++; $display("FAIL both_next got=%h exp=00000050", pc_next); end
    tick(); set_idle();
    pred_ret = 1; #1;
    n_checks++; if (pc_next !== 32'h0000_0204) begin n_fail++; $display("FAIL both_top got=%h exp=00000204", pc_next); end
    tick(); set_idle();
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL both_count got=%b exp=1", ras_empty); end
  endtask

  task automatic test_stall_mispredict();
    redirect_to(32'h0000_0300);
    pred_call = 1; pred_taken = 1; pc_pred = 32'h0000_0400; tick(); set_idle();
    for (int i = 0; i < 3; i++) begin
      stall_f = 1; pred_call = 1; tick();
      n_checks++; if (pc_f !== 32'h0000_0400) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=00000400", i, pc_f); end
    end
    mispredict = 1; cflow_taken = 0; pc_return = 32'h0000_0604; pc_jump = 32'h0000_0900;
    tick(); set_idle();
    n_checks++; if (pc_f !== 32'h0000_0604) begin n_fail++; $display("FAIL mispred_pc got=%h exp=00000604", pc_f); end
    pred_ret = 1; #1;
    n_checks++; if (pc_next !== 32'h0000_0304) begin n_fail++; $display("FAIL mispred_ras got=%h exp=00000304", pc_next); end
    tick(); set_idle();
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL mispred_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_reset_midop();
    redirect_to(32'h0000_0A00);
    pred_call = 1; tick(); tick();
    pred_call = 1; #2 rst_n = 0;
    m_pc = RV; m_ras.delete();
    #1;
    n_checks++; if (pc_f !== RV) begin n_fail++; $display("FAIL midrst_pc got=%h exp=%h", pc_f, RV); end
    n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got=%b exp=1", ras_empty); end
    set_idle();
    @(negedge clk) rst_n = 1;
    pred_ret = 1; #1;
    n_checks++; if (pc_next !== RV + 32'd4) begin n_fail++; $display("FAIL midrst_next got=%h exp=%h", pc_next, RV + 32'd4); end
    tick(); set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_idle();
      trap_redir  = ($urandom_range(0, 29) == 0);
      mispredict  = ($urandom_range(0, 11) == 0);
      cflow_taken = $urandom_range(0, 1) == 1;
      stall_f     = ($urandom_range(0, 4) == 0);
      pred_call   = ($urandom_range(0, 3) == 0);
      pred_ret    = ($urandom_range(0, 3) == 0);
      pred_taken  = ($urandom_range(0, 2) == 0);
      trap_addr   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      pc_jump     = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      pc_return   = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
      pc_pred     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ({$urandom(), 2'b00} & 32'hFFFF_FFFC);
      #1;
      n_checks++; if (pc_next !== model_next()) begin n_fail++; $display("FAIL rnd_next i=%0d got=%h exp=%h", i, pc_next, model_next()); end
      n_checks++; if (pcplus4_f !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_plus4 i=%0d got=%h exp=%h", i, pcplus4_f, m_pc + 32'd4); end
      tick();
      n_checks++; if (pc_f !== m_pc) begin n_fail++; $display("FAIL rnd_pc i=%0d got=%h exp=%h", i, pc_f, m_pc); end
      n_checks++; if (ras_empty !== (m_ras.size() == 0)) begin n_fail++; $display("FAIL rnd_empty i=%0d got=%b exp=%b", i, ras_empty, m_ras.size() == 0); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_sequential();
    test_pcplus4_wrap();
    test_trap_priority();
    test_call_return();
    test_overflow();
    test_call_ret_same();
    test_stall_mispredict();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
